imem_byte_loader: RTL and testbench

- Transmit end of the instruction-memory byte-load interface.
- Accepts 32-bit instruction words from a host-side source (UART bridge, switch/key front panel, or test ROM) over a valid/ready handshake.
- Serialises each word into four bytes, most significant byte first, so each word lands big-endian at ascending addresses.
- Drives each byte onto the imem byte-load port (instIn/enable) with a clean, slow strobe whose rising edge writes the byte, and tracks the receiver's write pointer.

---
 rtl/imem_load_pkg.sv | 19 +
 rtl/strobe_timer.sv | 31 +++
 rtl/imem_byte_loader.sv | 133 +++++++++++++
 tb/tb_imem_byte_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_pkg.sv
// rtl/imem_load_pkg.sv - shared state encoding and defaults for the imem byte loader
// Ports: none (package).
package imem_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } load_state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int DEF_MEM_BYTES   = 64;
    localparam int DEF_STROBE_HIGH = 2;
    localparam int DEF_STROBE_LOW  = 2;
    localparam int TIMER_WIDTH     = 8;

endpackage

// File: rtl/strobe_timer.sv
// rtl/strobe_timer.sv - down-counter timing the high and low phases of the byte strobe
// Ports: clk, reset (sync active-high), load/load_val (start a phase of load_val+1 cycles),
//        expired (current phase is in its final cycle).
module strobe_timer
    import imem_load_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A phase loaded with N-1 spends exactly N cycles before expiry is seen.
    assign expired = (cnt == '0);

endmodule

// File: rtl/imem_byte_loader.sv
// rtl/imem_byte_loader.sv - serialises 32-bit words MSB-first onto the imem byte-load strobe
// Ports: clk, reset (sync active-high); word_valid/word_last/word_in/word_ready (source handshake);
//        enable/inst_out (byte strobe and data to imem); byte_addr (mirror of imem write pointer);
//        busy (word in flight), done (last word written, sticky), full (byte_addr == MEM_BYTES).
module imem_byte_loader
    import imem_load_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH = 32,
    parameter int MEM_BYTES      = DEF_MEM_BYTES,
    parameter int STROBE_HIGH    = DEF_STROBE_HIGH,
    parameter int STROBE_LOW     = DEF_STROBE_LOW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      word_valid,
    input  logic                      word_last,
    input  logic [DATA_BUS_WIDTH-1:0] word_in,
    output logic                      word_ready,
    output logic                      enable,
    output logic [7:0]                inst_out,
    output logic [ADDR_BUS_WIDTH-1:0] byte_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      full
);

    localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_LIMIT = ADDR_BUS_WIDTH'(MEM_BYTES);
    localparam logic [1:0]                LAST_IDX   = 2'(BYTES_PER_WORD - 1);
    localparam logic [TIMER_WIDTH-1:0]    HIGH_LOAD  = TIMER_WIDTH'(STROBE_HIGH - 1);
    localparam logic [TIMER_WIDTH-1:0]    LOW_LOAD   = TIMER_WIDTH'(STROBE_LOW - 1);

    load_state_t                 state;
    logic [DATA_BUS_WIDTH-1:0]   word_q;
    logic                        last_q;
    logic [1:0]                  idx;
    logic                        timer_load;
    logic [TIMER_WIDTH-1:0]      timer_val;
    logic                        timer_expired;
    logic [ADDR_BUS_WIDTH-1:0]   next_addr;

    assign next_addr = byte_addr + 1'b1;

    // The timer is armed on the edge that enters HIGH and again on the edge that enters LOW.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = HIGH_LOAD;
        if (state == SETUP) begin
            timer_load = 1'b1;
        end else if (state == HIGH && timer_expired) begin
            timer_load = 1'b1;
            timer_val  = LOW_LOAD;
        end
    end

    strobe_timer #(
        .WIDTH(TIMER_WIDTH)
    ) u_strobe_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(timer_val),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word_q     <= '0;
            last_q     <= 1'b0;
            idx        <= '0;
            enable     <= 1'b0;
            inst_out   <= '0;
            byte_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            full       <= 1'b0;
            word_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (word_valid && word_ready) begin
                        // Remaining bytes are kept left-aligned so the next byte is always the top 8 bits.
                        word_q     <= {word_in[DATA_BUS_WIDTH-9:0], 8'h00};
                        last_q     <= word_last;
                        idx        <= '0;
                        busy       <= 1'b1;
                        inst_out   <= word_in[DATA_BUS_WIDTH-1 -: 8];
                        word_ready <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    enable <= 1'b1;
                    state  <= HIGH;
                end
                HIGH: begin
                    if (timer_expired) begin
                        enable <= 1'b0;
                        state  <= LOW;
                    end
                end
                LOW: begin
                    if (timer_expired) begin
                        byte_addr <= next_addr;
                        full      <= (next_addr == ADDR_LIMIT);
                        if (idx != LAST_IDX) begin
                            idx      <= idx + 1'b1;
                            inst_out <= word_q[DATA_BUS_WIDTH-1 -: 8];
                            word_q   <= {word_q[DATA_BUS_WIDTH-9:0], 8'h00};
                            state    <= SETUP;
                        end else if (last_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy       <= 1'b0;
                            word_ready <= (next_addr != ADDR_LIMIT);
                            state      <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_byte_loader.sv
// tb/tb_imem_byte_loader.sv - scoreboard bench for imem_byte_loader with an attached imem model
module tb_imem_byte_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        word_valid = 1'b0;
    logic        word_last = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_ready, enable, busy, done, full;
    logic [7:0]  inst_out;
    logic [15:0] byte_addr;

    logic        v2 = 1'b0;
    logic        l2 = 1'b0;
    logic [31:0] w2 = '0;
    logic        r2, en2, b2, d2, f2;
    logic [7:0]  io2;
    logic [15:0] a2;

    imem_byte_loader dut (
        .clk(clk), .reset(reset), .word_valid(word_valid), .word_last(word_last),
        .word_in(word_in), .word_ready(word_ready), .enable(enable), .inst_out(inst_out),
        .byte_addr(byte_addr), .busy(busy), .done(done), .full(full)
    );

    imem_byte_loader #(.STROBE_HIGH(1), .STROBE_LOW(3)) dut2 (
        .clk(clk), .reset(reset), .word_valid(v2), .word_last(l2),
        .word_in(w2), .word_ready(r2), .enable(en2), .inst_out(io2),
        .byte_addr(a2), .busy(b2), .done(d2), .full(f2)
    );

    typedef struct {
        logic [7:0]  data;
        logic [15:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          exp_ptr = 0;
    logic [7:0]  mem [0:127];
    int          ptr = 0;
    int          rises = 0;
    logic        prev_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // imem model plus scoreboard: every rising strobe writes one byte and is matched against the queue.
    always @(negedge clk) begin
        if (reset) begin
            ptr = 0;
        end else if (enable && !prev_en) begin
            mem[ptr[6:0]] = inst_out;
            ptr++;
            rises++;
            chk("strobe_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("strobe_byte", 32'(inst_out), 32'(e.data));
                chk("strobe_addr", 32'(byte_addr), 32'(e.addr));
            end
        end
        prev_en = enable;
    end

    task automatic present(input logic [31:0] w, input logic last, input bit push);
        exp_t e;
        word_in    = w;
        word_last  = last;
        word_valid = 1'b1;
        if (push) begin
            for (int b = 0; b < 4; b++) begin
                e.data = w[31-8*b -: 8];
                e.addr = 16'(exp_ptr);
                exp_ptr++;
                sb.push_back(e);
            end
        end
    endtask

    // Returns at the first negedge after the accepting edge; n counts negedges spent waiting.
    task automatic wait_accept(output int n);
        n = 0;
        while (word_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(word_ready === 1'b1), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        word_valid = 1'b0;
        v2         = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        sb.delete();
        exp_ptr = 0;
    endtask

    initial begin
        int          n;
        int          seen;
        int          r0;
        logic [31:0] w;
        logic [63:0] exp64;
        logic [31:0] tmp;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_word_ready", 32'(word_ready), 32'd1);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_inst_out", 32'(inst_out), 32'd0);
        chk("rst_byte_addr", 32'(byte_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst2_ready_busy_done_full", {28'd0, r2, b2, d2, f2}, 32'h8);
        reset = 1'b0;
        @(negedge clk);

        // Single word: strobe timing, return to IDLE, memory contents
        w = 32'hFFC4A303;
        present(w, 1'b0, 1'b1);
        wait_accept(n);
        word_valid = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k > 1) @(negedge clk);
            chk("t1_enable", 32'(enable), 32'(k inside {2, 3, 7, 8, 12, 13, 17, 18}));
            if (k == 20) chk("t1_busy_before_end", {30'd0, busy, word_ready}, 32'h2);
        end
        chk("t1_ready_again", 32'(word_ready), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_byte_addr", 32'(byte_addr), 32'd4);
        for (int b = 0; b < 4; b++) chk("t1_mem", 32'(mem[b]), 32'(w[31-8*b -: 8]));
        chk("t1_ptr", 32'(ptr), 32'd4);

        // Two words with valid held high; the second is the last word
        do_reset();
        present(32'h0064A423, 1'b0, 1'b1);
        wait_accept(n);
        present(32'h0062E233, 1'b1, 1'b1);
        wait_accept(n);
        chk("t2_next_accept_gap", 32'(n), 32'd20);
        word_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_ready_low", 32'(word_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_full", 32'(full), 32'd0);
        chk("t2_byte_addr", 32'(byte_addr), 32'd8);
        exp64 = 64'h0064A4230062E233;
        for (int i = 0; i < 8; i++) chk("t2_mem", 32'(mem[i]), 32'(exp64[63-8*i -: 8]));
        word_valid = 1'b1;
        repeat (10) @(negedge clk);
        word_valid = 1'b0;
        chk("t2_done_sticky", {30'd0, done, word_ready}, 32'h2);

        // Fill memory, then an excess word must be held off
        do_reset();
        for (int i = 0; i < 16; i++) begin
            present($urandom, 1'b0, 1'b1);
            wait_accept(n);
        end
        word_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_byte_addr", 32'(byte_addr), 32'd64);
        chk("t3_ready_low", 32'(word_ready), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_ptr", 32'(ptr), 32'd64);
        r0 = rises;
        present(32'hDEADBEEF, 1'b0, 1'b0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (word_ready !== 1'b0) seen++;
        end
        word_valid = 1'b0;
        chk("t3_never_ready", 32'(seen), 32'd0);
        chk("t3_no_strobe", 32'(rises), 32'(r0));
        chk("t3_addr_held", 32'(byte_addr), 32'd64);

        // Reset during HIGH of byte 2
        do_reset();
        present(32'h01128613, 1'b0, 1'b1);
        wait_accept(n);
        word_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("t4_in_high", 32'(enable), 32'd1);
        chk("t4_byte2", 32'(inst_out), 32'h86);
        chk("t4_addr_mid", 32'(byte_addr), 32'd2);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t4_enable", 32'(enable), 32'd0);
        chk("t4_byte_addr", 32'(byte_addr), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_ready", 32'(word_ready), 32'd1);
        @(negedge clk);
        reset   = 1'b0;
        exp_ptr = 0;
        present(32'hAABBCCDD, 1'b0, 1'b1);
        wait_accept(n);
        word_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_restart_addr", 32'(byte_addr), 32'd4);
        chk("t4_mem0", 32'(mem[0]), 32'hAA);
        chk("t4_mem3", 32'(mem[3]), 32'hDD);
        chk("t4_ptr", 32'(ptr), 32'd4);

        // STROBE_HIGH=1, STROBE_LOW=3 instance
        w2 = 32'h12345678;
        v2 = 1'b1;
        n = 0;
        while (r2 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_accept_in_time", 32'(r2 === 1'b1), 32'd1);
        @(posedge clk);
        @(negedge clk);
        v2 = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k > 1) @(negedge clk);
            chk("t5_enable", 32'(en2), 32'(k inside {2, 7, 12, 17}));
            if (k <= 20) begin
                tmp = w2 >> (8 * (3 - (k - 1) / 5));
                chk("t5_inst_stable", 32'(io2), tmp & 32'hFF);
            end
        end
        chk("t5_byte_addr", 32'(a2), 32'd4);
        chk("t5_ready", 32'(r2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
